// File: rtl/jala_pkg.sv
// Shared core constants and the write-port source select type.
`default_nettype none

package jala_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2 ** REG_AW;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_HOLD = 2'd2,
        SRC_LSU  = 2'd3
    } wb_src_e;
endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// Busy-register scoreboard: tracks pending long-latency writes and raises issue stall.
`default_nettype none

module wb_scoreboard #(
    parameter int REG_AW = jala_pkg::REG_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_issue_valid,
    input  logic                     i_issue_long,
    input  logic [REG_AW-1:0]        i_issue_rd,
    input  logic [REG_AW-1:0]        i_read_addr1,
    input  logic [REG_AW-1:0]        i_read_addr2,
    input  logic                     i_clr_valid,
    input  logic [REG_AW-1:0]        i_clr_rd,
    input  logic                     i_fwd_valid,
    input  logic [REG_AW-1:0]        i_fwd_addr,
    output logic                     o_stall,
    output logic [(2**REG_AW)-1:0]   o_busy_mask
);
    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_hit1;
    logic            w_hit2;
    logic            w_hit_rd;
    logic            w_set;

    // A register being written this cycle is forwarded by the register file, so it never stalls.
    assign w_hit1   = (i_read_addr1 != '0) && r_busy[i_read_addr1] &&
                      !(i_fwd_valid && (i_fwd_addr == i_read_addr1));
    assign w_hit2   = (i_read_addr2 != '0) && r_busy[i_read_addr2] &&
                      !(i_fwd_valid && (i_fwd_addr == i_read_addr2));
    assign w_hit_rd = (i_issue_rd != '0) && r_busy[i_issue_rd] &&
                      !(i_fwd_valid && (i_fwd_addr == i_issue_rd));

    assign o_stall  = i_issue_valid && (w_hit1 || w_hit2 || w_hit_rd);
    assign w_set    = i_issue_valid && i_issue_long && (i_issue_rd != '0) && !o_stall;

    // Set is applied after clear so a coincident set/clear leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_valid) begin
            w_busy_nxt[i_clr_rd] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy_mask = r_busy;
endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU/LSU result mux with one-entry LSU hold buffer and registered write port.
`default_nettype none

module wb_arbiter #(
    parameter int XLEN   = jala_pkg::XLEN,
    parameter int REG_AW = jala_pkg::REG_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic                     issue_long,
    input  logic [REG_AW-1:0]        issue_rd,
    input  logic                     alu_valid,
    input  logic [REG_AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    input  logic [REG_AW-1:0]        lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     lsu_ready,
    input  logic [REG_AW-1:0]        read_addr1,
    input  logic [REG_AW-1:0]        read_addr2,
    output logic                     stall,
    output logic                     write_en,
    output logic [REG_AW-1:0]        write_addr,
    output logic [XLEN-1:0]          write_data,
    output logic [(2**REG_AW)-1:0]   busy_mask
);
    import jala_pkg::*;

    logic              r_rdy_en;
    logic              r_hold_valid;
    logic [REG_AW-1:0] r_hold_rd;
    logic [XLEN-1:0]   r_hold_data;
    logic              r_wen;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;

    wb_src_e           w_src;
    logic [REG_AW-1:0] w_sel_rd;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_lsu_acc;
    logic              w_hold_cap;
    logic              w_clr_valid;

    // r_rdy_en keeps lsu_ready low until the first edge after reset release.
    assign lsu_ready   = r_rdy_en && !r_hold_valid;
    assign w_lsu_acc   = lsu_valid && lsu_ready;
    assign w_hold_cap  = w_lsu_acc && alu_valid;
    assign w_clr_valid = ((w_src == SRC_HOLD) || (w_src == SRC_LSU)) && (w_sel_rd != '0);

    always_comb begin
        w_src      = SRC_NONE;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (alu_valid) begin
            w_src      = SRC_ALU;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end else if (r_hold_valid) begin
            w_src      = SRC_HOLD;
            w_sel_rd   = r_hold_rd;
            w_sel_data = r_hold_data;
        end else if (w_lsu_acc) begin
            w_src      = SRC_LSU;
            w_sel_rd   = lsu_rd;
            w_sel_data = lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en     <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_hold_cap) begin
                r_hold_valid <= 1'b1;
                r_hold_rd    <= lsu_rd;
                r_hold_data  <= lsu_data;
            end else if (w_src == SRC_HOLD) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Writes to register 0 are consumed without touching the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= (w_src != SRC_NONE) && (w_sel_rd != '0);
            if ((w_src != SRC_NONE) && (w_sel_rd != '0)) begin
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign write_en   = r_wen;
    assign write_addr = r_waddr;
    assign write_data = r_wdata;

    wb_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue_valid (issue_valid),
        .i_issue_long  (issue_long),
        .i_issue_rd    (issue_rd),
        .i_read_addr1  (read_addr1),
        .i_read_addr2  (read_addr2),
        .i_clr_valid   (w_clr_valid),
        .i_clr_rd      (w_sel_rd),
        .i_fwd_valid   (r_wen),
        .i_fwd_addr    (r_waddr),
        .o_stall       (stall),
        .o_busy_mask   (busy_mask)
    );
endmodule

`default_nettype wire
